// File: rtl/seg_scan_controller.sv
// seg_scan_controller: 4-digit multiplexed 7-segment scan sequencer with a frame-end loaded display register.
// Optional SEG_SCAN_DIM_EN adds a per-frame brightness input limiting the lit phases.
module seg_scan_controller #(
  parameter int PRESCALE   = 1000,
  parameter int PRESCALE_W = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        data_valid,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0]  brightness,
`endif
  output logic        data_ready,
  output logic [3:0]  char_out,
  output logic [3:0]  anode,
  output logic [1:0]  digit_idx,
  output logic [2:0]  phase,
  output logic        frame_start
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;
  logic [0:0]            state, n_state;
  logic [15:0]           display_reg, n_disp;
  logic [PRESCALE_W-1:0] prescaler, n_pre;
  logic [2:0]            n_phase, lit_max;
  logic [1:0]            n_digit;
  logic                  tick, wrap, load, n_fs, n_lit;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0] bright_reg, n_bright;
  assign n_bright = n_fs ? brightness : bright_reg;
  assign lit_max  = (n_bright > 3'd6) ? 3'd6 : n_bright;
`else
  assign lit_max  = 3'd6;
`endif
  always_comb begin
    tick    = (state == SCAN) && (prescaler == PRESCALE_W'(PRESCALE - 1));
    wrap    = tick && (phase == 3'd7);
    load    = data_valid && data_ready;
    n_state = load ? SCAN : state;
    n_disp  = load ? data_in : display_reg;
    n_pre   = (state == IDLE || tick) ? '0 : prescaler + 1'b1;
    n_phase = tick ? phase + 3'd1 : phase;
    n_digit = wrap ? digit_idx + 2'd1 : digit_idx;
    n_fs    = (state == IDLE && load) || (wrap && digit_idx == 2'd3);
    // Phase 0 stays blank so the decoder settles on the new nibble before the anode turns on
    n_lit   = (n_state == SCAN) && (n_phase != 3'd0) && (n_phase <= lit_max);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      display_reg <= '0;
      prescaler   <= '0;
      digit_idx   <= '0;
      phase       <= '0;
      anode       <= 4'hf;
      char_out    <= '0;
      data_ready  <= 1'b1;
      frame_start <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      bright_reg  <= '0;
`endif
    end else begin
      state       <= n_state;
      display_reg <= n_disp;
      prescaler   <= n_pre;
      digit_idx   <= n_digit;
      phase       <= n_phase;
      anode       <= n_lit ? ~(4'b0001 << n_digit) : 4'hf;
      char_out    <= n_disp[{n_digit, 2'b00} +: 4];
      data_ready  <= (n_state == IDLE) || (n_digit == 2'd3 && n_phase == 3'd7);
      frame_start <= n_fs;
`ifdef SEG_SCAN_DIM_EN
      bright_reg  <= n_bright;
`endif
    end
  end
endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: directed scan/load/reset checks with a per-digit expectation queue.
module tb_seg_scan_controller;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready, frame_start;
  logic [3:0]  char_out, anode;
  logic [1:0]  digit_idx;
  logic [2:0]  phase;
  logic [7:0]  q[$];
  int          total = 0;
  int          bad = 0;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0]  brightness = 3'd6;
`endif
  seg_scan_controller #(.PRESCALE(2), .PRESCALE_W(2)) dut (
    .clock(clock),
    .reset(reset),
    .data_in(data_in),
    .data_valid(data_valid),
`ifdef SEG_SCAN_DIM_EN
    .brightness(brightness),
`endif
    .data_ready(data_ready),
    .char_out(char_out),
    .anode(anode),
    .digit_idx(digit_idx),
    .phase(phase),
    .frame_start(frame_start)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got %0h want %0h", tag, obs, expv);
    end
  endtask
  task automatic push_val(input logic [15:0] v);
    for (int d = 0; d < 4; d++) q.push_back({v[4*d +: 4], ~(4'b0001 << d)});
  endtask
  task automatic chk_idle(input string tag);
    chk(tag, {anode, char_out, data_ready, frame_start, digit_idx, phase}, {4'hf, 4'h0, 1'b1, 1'b0, 2'd0, 3'd0});
  endtask
  task automatic scan_frame(input int f, input int n);
    int d, ph, lit;
    logic [7:0] e;
    lit = 0;
    for (int c = 0; c < n; c++) begin
      d  = c / 16;
      ph = (c % 16) / 2;
      chk("frame_start", frame_start, c == 0);
      chk("digit_idx", digit_idx, d);
      chk("phase", phase, ph);
      chk("data_ready", data_ready, c >= 62);
      if (ph == 0 || ph == 7) chk("blank_anode", anode, 4'hf);
      if (anode != 4'hf) lit++;
      if (c % 16 == 5) begin
        if (q.size() == 0) chk("queue_empty", 1, 0);
        else begin
          e = q.pop_front();
          chk("char_out", char_out, e[7:4]);
          chk("lit_anode", anode, e[3:0]);
        end
      end
      if (f == 2 && c == 16) begin
        data_in = 16'h1234;
        data_valid = 1'b1;
        push_val(16'h1234);
      end
      if (f == 3 && c == 0) data_valid = 1'b0;
`ifdef SEG_SCAN_DIM_EN
      if (f == 5 && c == 10) brightness = 3'd3;
`endif
      step();
    end
    if (n == 64) chk("lit_cycles", lit, (f == 6) ? 24 : 48);
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    chk_idle("reset_state");
    for (int i = 0; i < 100; i++) begin
      step();
      chk_idle("idle_hold");
    end
    data_in = 16'h4A7C;
    data_valid = 1'b1;
    push_val(16'h4A7C);
    step();
    data_valid = 1'b0;
    scan_frame(1, 64);
    push_val(16'h4A7C);
    scan_frame(2, 64);
    scan_frame(3, 64);
    push_val(16'h1234);
    scan_frame(4, 40);
    chk("mid_frame_pos", {digit_idx, phase, anode, char_out}, {2'd2, 3'd4, 4'b1011, 4'h2});
    reset = 1'b1;
    data_in = 16'hFFFF;
    data_valid = 1'b1;
    step();
    chk_idle("mid_reset");
    q.delete();
    reset = 1'b0;
    data_valid = 1'b0;
    step();
    chk_idle("after_reset");
    data_in = 16'h5678;
    data_valid = 1'b1;
    push_val(16'h5678);
    step();
    data_valid = 1'b0;
    scan_frame(5, 64);
`ifdef SEG_SCAN_DIM_EN
    push_val(16'h5678);
    scan_frame(6, 64);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
